// File: rtl/seed_key_sequencer_pkg.sv
// Shared constants and types for the SEED key-schedule sequencing blocks.
// Counter limits are pre-cast to the counter width so comparisons stay width-clean.
package seed_key_sequencer_pkg;

    localparam int CYCLES_PER_ROUND   = 17;
    localparam int NUM_ROUNDS         = 16;
    localparam int KEY_BYTES          = 16;
    localparam int SK_BYTES_PER_ROUND = 4;

    localparam int CNT_W = 5;
    localparam int PTR_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    localparam cnt_t LAST_SLOT     = cnt_t'(CYCLES_PER_ROUND - 1);
    localparam cnt_t LAST_ROUND    = cnt_t'(NUM_ROUNDS - 1);
    localparam cnt_t FLUSH_ROUND   = cnt_t'(NUM_ROUNDS);
    localparam cnt_t LAST_SK_SLOT  = cnt_t'(SK_BYTES_PER_ROUND - 1);
    localparam cnt_t LAST_KEY_SLOT = cnt_t'(KEY_BYTES - 1);
    localparam ptr_t LAST_PTR      = ptr_t'(KEY_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/seed_key_sequencer_if.sv
// Key-byte ingress handshake: the master offers bytes, the slave accepts
// on in_valid && in_ready.
interface seed_key_sequencer_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/seed_byte_buffer.sv
// 16x8 register file holding the user key; one write port, asynchronous read
// so the replayed byte lines up with main_counter in the same cycle.
module seed_byte_buffer
    import seed_key_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  ptr_t       waddr,
    input  logic [7:0] wdata,
    input  ptr_t       raddr,
    output logic [7:0] rdata
);

    logic [7:0] rd_arr [KEY_BYTES];

    generate
        for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_entry
            logic [7:0] entry_q;
            logic [7:0] entry_d;

            always_comb begin
                entry_d = entry_q;
                if (we && (waddr == ptr_t'(gi))) begin
                    entry_d = wdata;
                end
            end

            always_ff @(posedge clk) begin
                entry_q <= entry_d;
            end

            assign rd_arr[gi] = entry_q;
        end
    endgenerate

    assign rdata = rd_arr[raddr];

endmodule

// File: rtl/seed_key_sequencer.sv
// Collects the 128-bit key, then free-runs the main/round counter sequence of the
// serialized SEED key schedule, replaying the key in round 0 and flagging SK bytes.
module seed_key_sequencer
    import seed_key_sequencer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    seed_key_sequencer_if.slave        kin,
    output logic [7:0]                 key_byte,
    output cnt_t                       main_counter,
    output cnt_t                       round_counter,
    output logic                       sk_valid,
    output logic                       busy,
    output logic                       done
);

    state_t state_q, state_d;
    ptr_t   wptr_q,  wptr_d;
    cnt_t   main_q,  main_d;
    cnt_t   round_q, round_d;
    logic   done_q,  done_d;
    logic   accept;
    logic [7:0] rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            main_q  <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            main_q  <= main_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        main_d  = main_q;
        round_d = round_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                main_d  = '0;
                round_d = '0;
                wptr_d  = '0;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (kin.in_valid) begin
                    accept = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    if (wptr_q == LAST_PTR) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // No stall path: the key schedule consumes one slot every cycle.
                if (main_q == LAST_SLOT) begin
                    main_d = '0;
                    if (round_q == LAST_ROUND) begin
                        round_d = FLUSH_ROUND;
                        state_d = FLUSH;
                    end else begin
                        round_d = round_q + 1'b1;
                    end
                end else begin
                    main_d = main_q + 1'b1;
                end
            end
            FLUSH: begin
                if (main_q == LAST_SK_SLOT) begin
                    state_d = IDLE;
                    main_d  = '0;
                    round_d = '0;
                    done_d  = 1'b1;
                end else begin
                    main_d = main_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    seed_byte_buffer u_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (wptr_q),
        .wdata (kin.in_data),
        .raddr (main_q[PTR_W-1:0]),
        .rdata (rd_data)
    );

    // Round-0 subkeys come out one round late, hence FLUSH drains the last window.
    always_comb begin
        kin.in_ready  = (state_q == LOAD);
        busy          = (state_q != IDLE);
        done          = done_q;
        main_counter  = main_q;
        round_counter = round_q;
        key_byte      = ((state_q == RUN) && (round_q == '0) && (main_q <= LAST_KEY_SLOT))
                        ? rd_data : 8'h00;
        sk_valid      = (state_q == FLUSH) ||
                        ((state_q == RUN) && (round_q != '0) && (main_q <= LAST_SK_SLOT));
    end

endmodule

// File: tb/tb_seed_key_sequencer.sv
// Randomized bench for seed_key_sequencer: a phase/offset model predicts every output
// each cycle, and per-run literal checks pin latency, window counts and key replay.
module tb_seed_key_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b1;
    logic [7:0] key_byte;
    logic [4:0] main_counter;
    logic [4:0] round_counter;
    logic       sk_valid;
    logic       busy;
    logic       done;

    seed_key_sequencer_if kif();

    seed_key_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .kin           (kif.slave),
        .key_byte      (key_byte),
        .main_counter  (main_counter),
        .round_counter (round_counter),
        .sk_valid      (sk_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [7:0] tb_key [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: mode 0 idle, 1 load (cnt = bytes taken), 2 run (cnt = cycles into run),
    // 3 flush (cnt = cycles into flush). Outputs follow from cnt by division/modulo.
    int         m_mode = 0;
    int         m_cnt  = 0;
    bit         m_done = 1'b0;
    logic [7:0] m_key [16];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_mode = 0; m_cnt = 0; m_done = 1'b0;
            end else begin
                m_done = 1'b0;
                case (m_mode)
                    0: if (start) begin m_mode = 1; m_cnt = 0; end
                    1: if (kif.in_valid) begin
                        m_key[m_cnt] = kif.in_data;
                        m_cnt++;
                        if (m_cnt == 16) begin m_mode = 2; m_cnt = 0; end
                    end
                    2: begin
                        m_cnt++;
                        if (m_cnt == 16 * 17) begin m_mode = 3; m_cnt = 0; end
                    end
                    default: begin
                        m_cnt++;
                        if (m_cnt == 4) begin m_mode = 0; m_cnt = 0; m_done = 1'b1; end
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                int e_main, e_round, e_key, e_sk;
                e_main  = (m_mode == 2) ? m_cnt % 17 : (m_mode == 3) ? m_cnt : 0;
                e_round = (m_mode == 2) ? m_cnt / 17 : (m_mode == 3) ? 16 : 0;
                e_key   = (m_mode == 2 && m_cnt < 16) ? int'(m_key[m_cnt]) : 0;
                e_sk    = (m_mode == 3 || (m_mode == 2 && m_cnt >= 17 && (m_cnt % 17) < 4)) ? 1 : 0;
                check("in_ready",      kif.in_ready,  (m_mode == 1) ? 1 : 0);
                check("busy",          busy,          (m_mode != 0) ? 1 : 0);
                check("done",          done,          m_done);
                check("main_counter",  main_counter,  e_main);
                check("round_counter", round_counter, e_round);
                check("key_byte",      key_byte,      e_key);
                check("sk_valid",      sk_valid,      e_sk);
            end
        end
    end

    // stall_mode: 0 always valid, 1 toggling 1,0,..., 2 random.
    task automatic do_run(input int stall_mode, input bit pokes, input bit abort);
        int n, sent, sk_cnt, rdy_cnt;
        bit fin, aborted, v;
        n = 0; sent = 0; sk_cnt = 0; rdy_cnt = 0; fin = 1'b0; aborted = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        check("load_entry_ready", kif.in_ready, 1);
        while (!fin && n < 1000) begin
            if (done) begin
                fin = 1'b1;
            end else begin
                if (sk_valid) sk_cnt++;
                if (kif.in_ready) rdy_cnt++;
                if (busy && !kif.in_ready && round_counter == 0 && main_counter == 5)
                    check("replay_slot5", key_byte, tb_key[5]);
                if (busy && !kif.in_ready && round_counter == 0 && main_counter == 16)
                    check("replay_slot16_zero", key_byte, 0);
                case (stall_mode)
                    0:       v = 1'b1;
                    1:       v = (n % 2 == 1);
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                kif.in_valid = v;
                kif.in_data  = (sent < 16) ? tb_key[sent] : 8'($urandom);
                if (v && kif.in_ready) sent++;
                start = pokes && ((kif.in_ready && rdy_cnt == 5) ||
                        (busy && !kif.in_ready && round_counter == 3 && main_counter == 7));
                reset = abort && round_counter == 9 && main_counter == 12;
                @(posedge clk); #1;
                n++;
                start = 1'b0;
                if (reset) begin
                    reset = 1'b0;
                    check("abort_busy",     busy,          0);
                    check("abort_main",     main_counter,  0);
                    check("abort_round",    round_counter, 0);
                    check("abort_sk_valid", sk_valid,      0);
                    check("abort_key_byte", key_byte,      0);
                    check("abort_in_ready", kif.in_ready,  0);
                    check("abort_done",     done,          0);
                    fin = 1'b1;
                    aborted = 1'b1;
                end
            end
        end
        kif.in_valid = 1'b0;
        check("run_ended_in_bound", fin, 1);
        if (fin && !aborted) begin
            if (stall_mode == 0) check("start_to_done_latency", n, 293);
            if (stall_mode == 0) check("in_ready_cycles", rdy_cnt, 16);
            check("sk_valid_cycles", sk_cnt, 64);
        end
        $display("run stall=%0d pokes=%0d abort=%0d cycles=%0d sk=%0d ready=%0d",
                 stall_mode, pokes, abort, n, sk_cnt, rdy_cnt);
    endtask

    initial begin
        kif.in_valid = 1'b0;
        kif.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check("reset_beats_start_busy",  busy,         0);
        check("reset_beats_start_ready", kif.in_ready, 0);
        check("reset_main",              main_counter, 0);
        check("reset_done",              done,         0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) tb_key[i] = 8'(i);
        do_run(0, 1'b0, 1'b0);
        do_run(1, 1'b1, 1'b0);   // begins in the done cycle of the previous run

        for (int i = 0; i < 16; i++) tb_key[i] = 8'($urandom);
        do_run(2, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) tb_key[i] = 8'(8'hFF - 8'(i));
        do_run(0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) tb_key[i] = 8'($urandom);
        do_run(2, 1'b1, 1'b0);

        @(posedge clk); #1;
        check("done_single_pulse", done, 0);
        check("idle_after_done",   busy, 0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seed_key_sequencer.md
Name: seed_key_sequencer

Overview:
- Upstream control stage for the 8-bit serialized SEED key schedule.
- Accepts the 128-bit user key as 16 bytes over a valid/ready handshake and buffers it.
- Then free-runs the main_counter / round_counter sequence the key schedule consumes, replaying the buffered key bytes during round 0.
- Flags the cycles in which the key schedule's subkey byte output is valid, and signals done.

Parameters:
- CYCLES_PER_ROUND, 17, main_counter counts 0..CYCLES_PER_ROUND-1 then wraps.
- NUM_ROUNDS, 16, round_counter counts 0..NUM_ROUNDS-1 in RUN.
- KEY_BYTES, 16, key bytes collected in LOAD.
- SK_BYTES_PER_ROUND, 4, output window length at main_counter 0..3.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin; honoured only in IDLE.
- in_valid  in  1  key byte valid.
- in_data  in  8  key byte; first accepted byte = key byte 0.
- in_ready  out  1  high only in LOAD.
- key_byte  out  8  byte driven into the key schedule's Key input.
- main_counter  out  5  intra-round byte slot, 0..16.
- round_counter  out  5  round index 0..15 in RUN, 16 in FLUSH.
- sk_valid  out  1  key-schedule SK output byte is valid this cycle.
- busy  out  1  high in LOAD, RUN and FLUSH.
- done  out  1  one-cycle pulse on FLUSH exit.

Behaviour:
- Reset (synchronous, active-high; dominates every other input, including mid-operation):
  - state=IDLE; all outputs 0; write pointer 0; buffer contents don't-care.
- IDLE:
  - counters held at 0; in_ready=0.
  - start=1 -> LOAD next cycle.
- LOAD:
  - in_ready=1; a byte is accepted when in_valid&in_ready and written to buf[wptr]; wptr increments.
  - Counters held at 0 throughout.
  - On acceptance of byte 15 -> RUN next cycle.
  - Stalls (in_valid=0) of any length are allowed.
  - start in LOAD is ignored.
- RUN:
  - Free-running; no stall possible.
  - main_counter increments every cycle; at 16 it wraps to 0 and round_counter increments.
  - key_byte = buf[main_counter] while round_counter==0 and main_counter<=15; otherwise key_byte=0.
  - sk_valid = (main_counter<=3) && (round_counter>=1).
  - Leaving round 15 at main_counter 16 -> FLUSH with main_counter=0 and round_counter=16.
  - start in RUN is ignored.
- FLUSH:
  - main_counter 0..3; sk_valid=1; key_byte=0.
  - After main_counter 3 -> IDLE; done=1 in the first IDLE cycle only.
  - round_counter and main_counter return to 0 in IDLE.
- Timing:
  - RUN lasts exactly 16×17=272 cycles; FLUSH exactly 4 cycles.
  - Total sk_valid cycles per run = 15×4 + 4 = 64.
  - start-to-done latency with no LOAD stalls = 1+16+272+4 = 293 cycles.
- Simultaneous events:
  - start together with reset -> reset wins.
  - start in the same cycle done is high -> accepted, LOAD next cycle.
- Counter widths:
  - 5-bit counters; values above 16 are never produced.
  - Comparisons are unsigned.

Decomposition:
- Shared package constants: CYCLES_PER_ROUND, NUM_ROUNDS, KEY_BYTES, SK_BYTES_PER_ROUND.
- Shared package typedef: state enum {IDLE, LOAD, RUN, FLUSH}, 2-bit encoding.
- The same package serves the data-path sequencer.
- One sub-module: seed_byte_buffer (16×8 register file, 4-bit write pointer/write enable, combinational read by 4-bit address).
- FSM and counters live in the top.

Test Plan:
- Reset, then start; in_valid=1 constantly with bytes 0x00..0x0F -> in_ready high 16 cycles; RUN begins; key_byte = 0x00..0x0F at main_counter 0..15 of round 0, 0x00 at 16; done exactly 293 cycles after start.
- LOAD with in_valid toggling 1,0,1,0 -> only valid bytes stored; counters stay 0 until the 16th acceptance; replay order still 0x00..0x0F.
- Full run, monitor counters -> main_counter sequence 0..16 repeating; round_counter 0..15 then 16 for 4 cycles; sk_valid asserted exactly 64 cycles, never in round 0.
- start pulsed at cycle 5 of LOAD and at main_counter 7 of round 3 -> no effect on the sequence; done occurs exactly once.
- reset asserted at round 9, main_counter 12 -> next cycle IDLE with all outputs 0; new start with key 0xFF..0xF0 replays the new bytes correctly.
- start asserted in the done cycle -> LOAD entered the next cycle; in_ready=1.
